// File: rtl/data_sram_responder.sv
// data_sram_responder: memory side of the core's sram-like data port.
// Byte-lane writes, LATENCY-deep read pipeline, range error, counters.
module data_sram_responder #(
    parameter int          ADDR_W  = 12,
    parameter int          LATENCY = 1,
    parameter logic [31:0] BASE    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [3:0]  we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        err,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [31:0]        mem [DEPTH];
    logic [31:0]        off;
    logic               in_range;
    logic [ADDR_W-1:0]  idx;
    logic               wr_req;
    logic               rd_req;
    logic [31:0]        pipe_data [LATENCY];
    logic [LATENCY-1:0] pipe_rd;
    logic [LATENCY-1:0] pipe_oor;

    // anything past the top of the window (or below BASE, via wrap) is out
    assign off      = addr - BASE;
    assign in_range = (off >> (ADDR_W + 2)) == 32'd0;
    assign idx      = off[ADDR_W+1:2];
    assign wr_req   = en && (we != 4'd0);
    assign rd_req   = en && (we == 4'd0);

    // byte-lane write port; reset only blocks the request, contents persist
    always_ff @(posedge clk) begin
        if (!reset && wr_req && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // snapshot the word at the request edge, then shift; flags qualify it
    always_ff @(posedge clk) begin
        if (rd_req) begin
            pipe_data[0] <= mem[idx];
        end
        for (int i = 1; i < LATENCY; i++) begin
            pipe_data[i] <= pipe_data[i-1];
        end
    end

    // read/err tags travel alongside the data; reset flushes in-flight reads
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_rd  <= '0;
            pipe_oor <= '0;
        end else begin
            pipe_rd[0]  <= rd_req;
            pipe_oor[0] <= en && !in_range;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_rd[i]  <= pipe_rd[i-1];
                pipe_oor[i] <= pipe_oor[i-1];
            end
        end
    end

    // result register: out-of-range reads return zero, rdata holds otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata       <= 32'd0;
            rdata_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            rdata_valid <= pipe_rd[LATENCY-1];
            err         <= pipe_oor[LATENCY-1];
            if (pipe_rd[LATENCY-1]) begin
                rdata <= pipe_oor[LATENCY-1] ? 32'd0 : pipe_data[LATENCY-1];
            end
        end
    end

    // debug counters count only accepted in-range accesses
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt <= 32'd0;
            wr_cnt <= 32'd0;
        end else begin
            if (rd_req && in_range) begin
                rd_cnt <= rd_cnt + 32'd1;
            end
            if (wr_req && in_range) begin
                wr_cnt <= wr_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: three latencies share one stimulus stream and
// are checked every cycle against a request-record model of the memory.
module tb_data_sram_responder;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk;
    logic        reset;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic [31:0] rdata_o [1:3];
    logic        vld_o   [1:3];
    logic        err_o   [1:3];
    logic [31:0] rdc_o   [1:3];
    logic [31:0] wrc_o   [1:3];

    int total = 0;
    int bad   = 0;
    bit chk_on = 0;

    data_sram_responder #(.ADDR_W(6), .LATENCY(1), .BASE(BASE)) dut1 (
        .clk(clk), .reset(reset), .en(en), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata_o[1]), .rdata_valid(vld_o[1]),
        .err(err_o[1]), .rd_cnt(rdc_o[1]), .wr_cnt(wrc_o[1])
    );
    data_sram_responder #(.ADDR_W(6), .LATENCY(2), .BASE(BASE)) dut2 (
        .clk(clk), .reset(reset), .en(en), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata_o[2]), .rdata_valid(vld_o[2]),
        .err(err_o[2]), .rd_cnt(rdc_o[2]), .wr_cnt(wrc_o[2])
    );
    data_sram_responder #(.ADDR_W(6), .LATENCY(3), .BASE(BASE)) dut3 (
        .clk(clk), .reset(reset), .en(en), .we(we), .addr(addr),
        .wdata(wdata), .rdata(rdata_o[3]), .rdata_valid(vld_o[3]),
        .err(err_o[3]), .rd_cnt(rdc_o[3]), .wr_cnt(wrc_o[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // model: word array plus records of requests made at recent edges
    logic [31:0] mem_m [64];
    bit          rec_rd  [0:3];
    bit          rec_oor [0:3];
    logic [31:0] rec_dat [0:3];
    logic [31:0] e_rdata [1:3];
    bit          e_vld   [1:3];
    bit          e_err   [1:3];
    logic [31:0] e_rd;
    logic [31:0] e_wr;

    task automatic check(input string nm, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // model update at each edge: result of latency L comes from the
    // request made L edges ago
    always @(posedge clk) begin
        logic [31:0] off;
        logic [5:0]  wi;
        bit          inr;
        if (reset) begin
            for (int l = 1; l <= 3; l++) begin
                e_rdata[l] = 32'd0;
                e_vld[l]   = 0;
                e_err[l]   = 0;
            end
            for (int k = 0; k <= 3; k++) begin
                rec_rd[k]  = 0;
                rec_oor[k] = 0;
                rec_dat[k] = 32'd0;
            end
            e_rd = 32'd0;
            e_wr = 32'd0;
        end else begin
            for (int l = 1; l <= 3; l++) begin
                e_vld[l] = rec_rd[l-1];
                e_err[l] = rec_oor[l-1];
                if (rec_rd[l-1]) e_rdata[l] = rec_dat[l-1];
            end
            for (int k = 3; k > 0; k--) begin
                rec_rd[k]  = rec_rd[k-1];
                rec_oor[k] = rec_oor[k-1];
                rec_dat[k] = rec_dat[k-1];
            end
            rec_rd[0]  = 0;
            rec_oor[0] = 0;
            rec_dat[0] = 32'd0;
            if (en) begin
                off = addr - BASE;
                inr = off < 32'd256;
                wi  = off[7:2];
                rec_oor[0] = !inr;
                if (we != 4'd0) begin
                    if (inr) begin
                        for (int b = 0; b < 4; b++)
                            if (we[b]) mem_m[wi][8*b +: 8] = wdata[8*b +: 8];
                        e_wr = e_wr + 32'd1;
                    end
                end else begin
                    rec_rd[0]  = 1;
                    rec_dat[0] = inr ? mem_m[wi] : 32'd0;
                    if (inr) e_rd = e_rd + 32'd1;
                end
            end
        end
    end

    // per-cycle comparison of every DUT against the model
    always @(negedge clk) begin
        if (chk_on) begin
            for (int l = 1; l <= 3; l++) begin
                check($sformatf("rdata L%0d", l), rdata_o[l], e_rdata[l]);
                check($sformatf("valid L%0d", l), 32'(vld_o[l]), 32'(e_vld[l]));
                check($sformatf("err L%0d", l), 32'(err_o[l]), 32'(e_err[l]));
                check($sformatf("rd_cnt L%0d", l), rdc_o[l], e_rd);
                check($sformatf("wr_cnt L%0d", l), wrc_o[l], e_wr);
            end
        end
    end

    task automatic step(input logic e, input logic [3:0] w,
                        input logic [31:0] a, input logic [31:0] d);
        en = e;
        we = w;
        addr = a;
        wdata = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 4'h0, 32'd0, 32'd0);
    endtask

    initial begin
        logic [3:0]  w;
        logic [31:0] a;
        reset = 1'b1;
        idle();
        chk_on = 1;
        idle();
        reset = 1'b0;
        for (int l = 1; l <= 3; l++) begin
            check("reset rdata", rdata_o[l], 32'd0);
            check("reset valid", 32'(vld_o[l]), 32'd0);
            check("reset rd_cnt", rdc_o[l], 32'd0);
        end

        // write then read-after-write, single-cycle valid pulse
        step(1'b1, 4'hF, BASE + 32'h10, 32'hDEADBEEF);
        step(1'b1, 4'h0, BASE + 32'h10, 32'd0);
        idle();
        check("raw rdata", rdata_o[1], 32'hDEADBEEF);
        check("raw model", e_rdata[1], 32'hDEADBEEF);
        check("raw valid", 32'(vld_o[1]), 32'd1);
        check("raw wr_cnt", wrc_o[1], 32'd1);
        check("raw rd_cnt", rdc_o[1], 32'd1);
        idle();
        check("valid pulse", 32'(vld_o[1]), 32'd0);
        check("rdata hold", rdata_o[1], 32'hDEADBEEF);

        // byte-lane merge
        step(1'b1, 4'hF, BASE + 32'h20, 32'h11223344);
        step(1'b1, 4'b0101, BASE + 32'h20, 32'hAABBCCDD);
        step(1'b1, 4'h0, BASE + 32'h20, 32'd0);
        idle();
        check("lane merge", rdata_o[1], 32'h11BB33DD);
        check("lane model", e_rdata[1], 32'h11BB33DD);

        // latency 3, pipelined reads, write inside the window
        step(1'b1, 4'hF, BASE + 32'h0, 32'd1);
        step(1'b1, 4'hF, BASE + 32'h4, 32'd2);
        step(1'b1, 4'hF, BASE + 32'h8, 32'd3);
        step(1'b1, 4'h0, BASE + 32'h0, 32'd0);
        step(1'b1, 4'h0, BASE + 32'h4, 32'd0);
        step(1'b1, 4'h0, BASE + 32'h8, 32'd0);
        step(1'b1, 4'hF, BASE + 32'h4, 32'd9);
        check("l3 first", rdata_o[3], 32'd1);
        check("l3 v1", 32'(vld_o[3]), 32'd1);
        idle();
        check("l3 snapshot", rdata_o[3], 32'd2);
        check("l3 v2", 32'(vld_o[3]), 32'd1);
        idle();
        check("l3 third", rdata_o[3], 32'd3);
        check("l3 v3", 32'(vld_o[3]), 32'd1);
        idle();
        check("l3 v end", 32'(vld_o[3]), 32'd0);
        step(1'b1, 4'h0, BASE + 32'h4, 32'd0);
        idle();
        check("war new", rdata_o[1], 32'd9);

        // out-of-range read and write
        step(1'b1, 4'h0, BASE + 32'h100, 32'd0);
        idle();
        check("oor rdata", rdata_o[1], 32'd0);
        check("oor valid", 32'(vld_o[1]), 32'd1);
        check("oor err", 32'(err_o[1]), 32'd1);
        check("oor rd_cnt", rdc_o[1], 32'd6);
        step(1'b1, 4'hF, BASE + 32'h100, 32'h55555555);
        idle();
        check("oor w err", 32'(err_o[1]), 32'd1);
        check("oor w valid", 32'(vld_o[1]), 32'd0);
        check("oor wr_cnt", wrc_o[1], 32'd7);
        step(1'b1, 4'h0, BASE + 32'h0, 32'd0);
        idle();
        check("oor no alias", rdata_o[1], 32'd1);

        // reset flushes an in-flight latency-2 read
        step(1'b1, 4'h0, BASE + 32'h10, 32'd0);
        reset = 1'b1;
        idle();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("flush valid", 32'(vld_o[2]), 32'd0);
            idle();
        end
        check("flush rdata", rdata_o[2], 32'd0);
        check("flush rd_cnt", rdc_o[2], 32'd0);
        check("flush wr_cnt", wrc_o[2], 32'd0);
        step(1'b1, 4'h0, BASE + 32'h10, 32'd0);
        idle();
        idle();
        check("retain", rdata_o[2], 32'hDEADBEEF);

        // low address bits ignored, we without en ignored
        step(1'b1, 4'h0, BASE + 32'h13, 32'd0);
        idle();
        check("addr lsb", rdata_o[1], 32'hDEADBEEF);
        step(1'b0, 4'hF, BASE + 32'h10, 32'h0);
        check("en0 wr_cnt", wrc_o[1], 32'd0);
        step(1'b1, 4'h0, BASE + 32'h10, 32'd0);
        idle();
        check("en0 mem", rdata_o[1], 32'hDEADBEEF);

        // fill every word so random reads are well defined
        for (int i = 0; i < 64; i++)
            step(1'b1, 4'hF, BASE + 32'(i * 4), $urandom);

        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 149) == 0);
            w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            case ($urandom_range(0, 9))
                0: a = BASE + 32'h100 + 32'($urandom_range(0, 1023));
                1: a = BASE - 32'd1 - 32'($urandom_range(0, 1023));
                default: a = BASE + 32'($urandom_range(0, 255));
            endcase
            step($urandom_range(0, 3) != 0, w, a, $urandom);
        end
        reset = 1'b0;
        for (int i = 0; i < 5; i++) idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Responder (memory side) of the CPU core's sram-like data interface (en / we / addr / wdata / rdata).
- Models a single-port synchronous data RAM with byte-lane writes and a configurable read pipeline latency.
- Adds an out-of-range error pulse and debug access counters.
- Sits outside the CPU top and is driven directly by its registered data_sram_* outputs; it also serves as the testbench and FPGA data memory.

Parameters:
- ADDR_W, 12: word-address width; depth = 2^ADDR_W 32-bit words.
- LATENCY, 1: read latency in cycles, legal range 1..4; the core requires 1.
- BASE, 32'h0000_0000: byte address of word 0; must be aligned to 4*2^ADDR_W.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- en  input  1  access request for this cycle
- we  input  4  byte write enables; we[i] covers wdata[8i+7:8i]; any bit set = write, 0 = read
- addr  input  32  byte address; addr[1:0] ignored
- wdata  input  32  write data
- rdata  output  32  read data
- rdata_valid  output  1  one-cycle pulse when rdata carries a new read result
- err  output  1  one-cycle pulse, LATENCY cycles after an out-of-range access
- rd_cnt  output  32  count of accepted reads
- wr_cnt  output  32  count of accepted writes

Behaviour:
- Clock and reset: reset, synchronous, active-high; clock clk. Everything updates on the clk rising edge.
- Reset values: rdata=0, rdata_valid=0, err=0, rd_cnt=0, wr_cnt=0. The read pipeline is flushed.
- Memory contents are NOT cleared by reset. Simulation init is all-zero unless preloaded.
- Address decode:
  - off = addr - BASE; in range iff off < 4*2^ADDR_W.
  - Word index = off[ADDR_W+1:2].
- Write (en=1, we!=0, in range):
  - At the edge, each lane with we[i]=1 takes wdata lane i; other lanes are unchanged.
  - wr_cnt += 1 (wraps modulo 2^32).
  - No rdata_valid is produced; rdata holds its previous value.
- Read (en=1, we=0, in range):
  - The array word is sampled at the request edge into pipeline stage 1.
  - It shifts through LATENCY-1 further registers.
  - rdata updates and rdata_valid=1 exactly LATENCY cycles after the request edge. For LATENCY=1, data requested at edge t is visible after edge t+1, matching the core's expectation.
  - rd_cnt += 1.
- Read-after-write: a write at edge t followed by a read of the same word at edge t+1 returns the new data.
- Write-after-read: a read at edge t returns the pre-write contents even if a write to the same word occurs at edge t+1..t+LATENCY-1. The snapshot is taken at the request.
- Back-to-back reads: one read is accepted per cycle, fully pipelined. Results return in order with rdata_valid high on consecutive cycles.
- rdata hold: rdata keeps the last read result until the next read result. rdata_valid is low in non-result cycles.
- en=0: no access and no counter change; the pipeline continues shifting.
- Out of range:
  - Write: dropped, memory unchanged, wr_cnt unchanged.
  - Read: returns 0 with rdata_valid=1 at normal latency; rd_cnt unchanged.
  - Both cases: err pulses, aligned to the LATENCY slot of the access.
- Reset mid-operation:
  - In-flight reads are discarded; no rdata_valid appears after reset deasserts.
  - A write presented in the same cycle as reset=1 is dropped.
- Errors: there is no error state or FSM error recovery beyond err. we with en=0 is ignored.
- Implementation: a plain reg array indexed by word. Per-lane writes must infer byte-write BRAM.

Test Plan:
- Reset, then write en=1 we=4'hF addr=BASE+0x10 wdata=32'hDEADBEEF; read 0x10 next cycle → after 1 cycle rdata=32'hDEADBEEF, rdata_valid=1 for exactly one cycle; wr_cnt=1, rd_cnt=1.
- Word 0x20 holds 32'h11223344; write we=4'b0101 wdata=32'hAABBCCDD; read 0x20 → rdata=32'h11BB33DD.
- LATENCY=3: reads at consecutive cycles to 0x0, 0x4, 0x8 holding 1, 2, 3 → rdata_valid high cycles t+3..t+5 with rdata 1, 2, 3. A write of 9 to 0x4 at t+1 still yields 2.
- Read addr=BASE+4*2^ADDR_W → rdata=0, rdata_valid=1, err=1 one cycle later, rd_cnt unchanged. Out-of-range write → memory and wr_cnt unchanged, err pulses.
- Issue read of 0x10 at LATENCY=2, assert reset the next cycle → rdata_valid never rises, rdata=0, counters=0. A subsequent read of 0x10 still returns 32'hDEADBEEF (memory retained).
- Read with addr[1:0]=2'b11 at 0x13 → same result as 0x10. en=0 with we=4'hF → no write, wr_cnt unchanged.
